// File: rtl/env_rom_arbiter.sv
// ---------------------------------------------------------------------------
// env_rom_arbiter
//   Two-requester arbiter in front of a single sprite/tile ROM. A request won
//   in IDLE latches the winner's sprite select and start word (ID/X/Y). The
//   block then issues BURST_LEN consecutive ROM reads along the row, with the
//   column wrapping 31->0. Each read returns one cycle later on the shared
//   DATA bus, qualified by the winner's DVALID.
//
//   Optional feature macro: ENV_ARB_FIXED_PRIO_EN
//     defined   -> requester 0 always wins simultaneous requests
//     undefined -> round-robin (the requester not served last wins a tie;
//                  requester 0 has priority out of reset)
//
//   Parameters
//     BURST_LEN     8-pixel words fetched per grant (1..32)
//
//   Ports
//     CLOCK_50      in   single clock, rising edge
//     RESET_N       in   asynchronous active-low reset
//     REQ0/REQ1     in   fetch request, held until the matching GNT
//     ID0/ID1       in   sprite/tile select of each requester
//     X0/X1, Y0/Y1  in   start word column / row of each requester (5b)
//     GNT0/GNT1     out  one-cycle grant pulse
//     DVALID0/1     out  DATA valid for requester 0/1
//     DATA          out  returned pixel word (ROM data pass-through)
//     DLAST         out  final word of the burst
//     R_ENV         out  ROM read enable
//     SPRITE_ID/X/Y out  ROM address controls, hold between bursts
//     SPRITE_PIXEL  in   ROM data, valid the cycle after R_ENV
//     BUSY          out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module env_rom_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       ID0,
  input  logic       ID1,
  input  logic [4:0] X0,
  input  logic [4:0] X1,
  input  logic [4:0] Y0,
  input  logic [4:0] Y1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DVALID0,
  output logic       DVALID1,
  output logic [7:0] DATA,
  output logic       DLAST,
  output logic       R_ENV,
  output logic       SPRITE_ID,
  output logic [4:0] SPRITE_X,
  output logic [4:0] SPRITE_Y,
  input  logic [7:0] SPRITE_PIXEL,
  output logic       BUSY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Beat counter spans 0..BURST_LEN-1, so 5 bits cover the legal range.
  localparam int         CW     = 5;
  localparam logic [CW-1:0] LAST_K = CW'(BURST_LEN - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner;     // requester currently being served
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_dv0;
  logic          r_dv1;
  logic          r_dlast;
  logic          r_id;
  logic [4:0]    r_x;
  logic [4:0]    r_y;

  logic          w_req_any;
  logic          w_win;       // 0 -> requester 0 wins, 1 -> requester 1
  logic          w_issue;
  logic          w_last_beat;

  assign w_req_any   = REQ0 | REQ1;
  assign w_issue     = (r_state == S_ISSUE);
  assign w_last_beat = w_issue && (r_cnt == LAST_K);

`ifdef ENV_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks.
  assign w_win = ~REQ0;
`else
  // r_last remembers who was served most recently; reset value 1 hands the
  // first tie after reset to requester 0.
  logic r_last;

  assign w_win = (REQ0 & REQ1) ? ~r_last : REQ1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_req_any) begin
      r_last <= w_win;
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_dv0   <= 1'b0;
      r_dv1   <= 1'b0;
      r_dlast <= 1'b0;
      r_id    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      // Grant is a single-cycle pulse; data valid trails each issue by one
      // cycle, matching the ROM's one-cycle read latency.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_dv0   <= w_issue & ~r_owner;
      r_dv1   <= w_issue &  r_owner;
      r_dlast <= w_last_beat;

      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <=  w_win;
            r_id    <= w_win ? ID1 : ID0;
            r_x     <= w_win ? X1  : X0;
            r_y     <= w_win ? Y1  : Y0;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_last_beat) begin
            // Column is not advanced after the final read so the address
            // outputs keep the last driven value.
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_x   <= r_x + 1'b1;   // natural 5-bit wrap 31 -> 0
          end
        end
        S_DRAIN: begin
          // Final read data is returned in this cycle.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT0      = r_gnt0;
  assign GNT1      = r_gnt1;
  assign DVALID0   = r_dv0;
  assign DVALID1   = r_dv1;
  assign DLAST     = r_dlast;
  assign DATA      = SPRITE_PIXEL;
  assign R_ENV     = w_issue;
  assign SPRITE_ID = r_id;
  assign SPRITE_X  = r_x;
  assign SPRITE_Y  = r_y;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_env_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_env_rom_arbiter
//   Directed scoreboard bench. Each stimulus step pushes the expected grant,
//   ROM reads and returned words; a monitor on the falling clock edge pops
//   and compares whenever the DUT shows GNT, R_ENV or DVALID. The ROM model
//   returns {ID, Y[1:0], X} one cycle after each read.
// ---------------------------------------------------------------------------
module tb_env_rom_arbiter;

  localparam int BL = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       REQ0 = 0, REQ1 = 0, ID0 = 0, ID1 = 0;
  logic [4:0] X0 = 0, X1 = 0, Y0 = 0, Y1 = 0;
  logic       GNT0, GNT1, DVALID0, DVALID1, DLAST, R_ENV, SPRITE_ID, BUSY;
  logic [7:0] DATA;
  logic [7:0] SPRITE_PIXEL = 8'h00;
  logic [4:0] SPRITE_X, SPRITE_Y;

  env_rom_arbiter #(.BURST_LEN(BL)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .ID0(ID0), .ID1(ID1),
    .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1),
    .GNT0(GNT0), .GNT1(GNT1), .DVALID0(DVALID0), .DVALID1(DVALID1),
    .DATA(DATA), .DLAST(DLAST), .R_ENV(R_ENV), .SPRITE_ID(SPRITE_ID),
    .SPRITE_X(SPRITE_X), .SPRITE_Y(SPRITE_Y), .SPRITE_PIXEL(SPRITE_PIXEL),
    .BUSY(BUSY)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ROM model: one-cycle read latency.
  always @(posedge CLOCK_50)
    if (R_ENV) SPRITE_PIXEL <= {SPRITE_ID, SPRITE_Y[1:0], SPRITE_X};

  typedef struct { bit r; int gap; }                gt_t;
  typedef struct { bit id; bit [4:0] x; bit [4:0] y; } rd_t;
  typedef struct { bit r; bit [7:0] d; bit l; }     dt_t;

  gt_t gq[$];
  rd_t rq[$];
  dt_t dq[$];
  gt_t g;
  rd_t rr;
  dt_t dd;

  int n_chk = 0, n_fail = 0, cyc = 0, last_gnt = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Expected burst: grant to requester r (gap = required cycles since the
  // previous grant, 0 = unchecked), then four reads at the hand-listed columns.
  task automatic push_burst(input bit r, input bit id, input bit [4:0] y, input int gap,
                            input bit [4:0] x0, input bit [4:0] x1,
                            input bit [4:0] x2, input bit [4:0] x3);
    bit [4:0] xs[4];
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    gq.push_back(gt_t'{r, gap});
    for (int k = 0; k < 4; k++) begin
      rq.push_back(rd_t'{id, xs[k], y});
      dq.push_back(dt_t'{r, {id, y[1:0], xs[k]}, k == 3});
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge CLOCK_50) begin
    if (RESET_N) begin
      if (GNT0 | GNT1) begin
        chk("gnt_excl", {31'd0, GNT0 & GNT1}, 0);
        if (gq.size() == 0) flag("gnt_unexpected");
        else begin
          g = gq.pop_front();
          chk("gnt_who", {31'd0, GNT1}, {31'd0, g.r});
          if (g.gap != 0) chk("gnt_gap", cyc - last_gnt, g.gap);
        end
        last_gnt = cyc;
      end
      if (R_ENV) begin
        if (rq.size() == 0) flag("read_unexpected");
        else begin
          rr = rq.pop_front();
          chk("rd_id", {31'd0, SPRITE_ID}, {31'd0, rr.id});
          chk("rd_x",  {27'd0, SPRITE_X},  {27'd0, rr.x});
          chk("rd_y",  {27'd0, SPRITE_Y},  {27'd0, rr.y});
        end
      end
      if (DVALID0 | DVALID1) begin
        chk("dv_excl", {31'd0, DVALID0 & DVALID1}, 0);
        if (dq.size() == 0) flag("dvalid_unexpected");
        else begin
          dd = dq.pop_front();
          chk("dv_who", {31'd0, DVALID1}, {31'd0, dd.r});
          chk("data",   {24'd0, DATA},    {24'd0, dd.d});
          chk("dlast",  {31'd0, DLAST},   {31'd0, dd.l});
        end
      end else if (DLAST) begin
        flag("dlast_without_dvalid");
      end
    end
  end

  // Returns number of falling edges until a grant was seen.
  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!(GNT0 | GNT1) && n < 50);
    if (!(GNT0 | GNT1)) flag("gnt_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (BUSY && n < 50);
    if (BUSY) flag("idle_timeout");
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_gq"}, gq.size(), 0);
    chk({nm, "_rq"}, rq.size(), 0);
    chk({nm, "_dq"}, dq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge CLOCK_50);
    // Reset state
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_renv", {31'd0, R_ENV}, 0);
    chk("rst_gnt",  {30'd0, GNT1, GNT0}, 0);
    chk("rst_dv",   {30'd0, DVALID1, DVALID0}, 0);
    chk("rst_dlast",{31'd0, DLAST}, 0);
    chk("rst_addr", {21'd0, SPRITE_ID, SPRITE_X, SPRITE_Y}, 0);
    RESET_N = 1'b1;

    // Single requester 0 burst: X 2..5, Y 7, ID 1; grant after one edge.
    push_burst(0, 1, 5'd7, 0, 5'd2, 5'd3, 5'd4, 5'd5);
    REQ0 = 1; ID0 = 1; X0 = 5'd2; Y0 = 5'd7;
    wait_gnt(n);
    chk("t1_gnt_latency", n, 1);
    REQ0 = 0;
    wait_idle();
    chk_drained("t1");

    // Column wrap within the row.
    push_burst(0, 0, 5'd3, 0, 5'd30, 5'd31, 5'd0, 5'd1);
    REQ0 = 1; ID0 = 0; X0 = 5'd30; Y0 = 5'd3;
    wait_gnt(n);
    REQ0 = 0;
    wait_idle();
    chk_drained("t2");

    // Requester 1 raised during requester 0's burst: grant spacing 6.
    push_burst(0, 1, 5'd12, 0, 5'd8, 5'd9, 5'd10, 5'd11);
    push_burst(1, 0, 5'd4, 6, 5'd17, 5'd18, 5'd19, 5'd20);
    REQ0 = 1; ID0 = 1; X0 = 5'd8; Y0 = 5'd12;
    ID1 = 0; X1 = 5'd17; Y1 = 5'd4;
    wait_gnt(n);
    REQ0 = 0; REQ1 = 1;
    wait_gnt(n);
    REQ1 = 0;
    wait_idle();
    chk_drained("t4");

    // Both held high: requester 1 was served last, so 0,1,0,1.
    ID0 = 0; X0 = 5'd5;  Y0 = 5'd1;
    ID1 = 1; X1 = 5'd28; Y1 = 5'd9;
`ifdef ENV_ARB_FIXED_PRIO_EN
    push_burst(0, 0, 5'd1, 0, 5'd5, 5'd6, 5'd7, 5'd8);
    push_burst(0, 0, 5'd1, 6, 5'd5, 5'd6, 5'd7, 5'd8);
    push_burst(0, 0, 5'd1, 6, 5'd5, 5'd6, 5'd7, 5'd8);
    push_burst(0, 0, 5'd1, 6, 5'd5, 5'd6, 5'd7, 5'd8);
`else
    push_burst(0, 0, 5'd1, 0, 5'd5,  5'd6,  5'd7,  5'd8);
    push_burst(1, 1, 5'd9, 6, 5'd28, 5'd29, 5'd30, 5'd31);
    push_burst(0, 0, 5'd1, 6, 5'd5,  5'd6,  5'd7,  5'd8);
    push_burst(1, 1, 5'd9, 6, 5'd28, 5'd29, 5'd30, 5'd31);
`endif
    REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 4; i++) wait_gnt(n);
    REQ0 = 0; REQ1 = 0;
    wait_idle();
    chk_drained("t3");

    // Reset during the second issue cycle of a requester 0 burst.
    push_burst(0, 1, 5'd2, 0, 5'd10, 5'd11, 5'd12, 5'd13);
    REQ0 = 1; ID0 = 1; X0 = 5'd10; Y0 = 5'd2;
    wait_gnt(n);
    REQ0 = 0;
    @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_renv", {31'd0, R_ENV}, 0);
    chk("t5_dv",   {30'd0, DVALID1, DVALID0}, 0);
    chk("t5_busy", {31'd0, BUSY}, 0);
    chk("t5_addr", {21'd0, SPRITE_ID, SPRITE_X, SPRITE_Y}, 0);
    chk("t5_rq_left", rq.size(), 3);
    chk("t5_dq_left", dq.size(), 4);
    gq.delete(); rq.delete(); dq.delete();
    repeat (2) @(negedge CLOCK_50);
    // Priority back to requester 0; arbitration on the first edge after release.
    push_burst(0, 0, 5'd6, 0, 5'd0, 5'd1, 5'd2, 5'd3);
    ID0 = 0; X0 = 5'd0; Y0 = 5'd6;
    REQ0 = 1; REQ1 = 1;
    RESET_N = 1'b1;
    wait_gnt(n);
    chk("t5_gnt_latency", n, 1);
    REQ0 = 0; REQ1 = 0;
    wait_idle();
    repeat (2) @(negedge CLOCK_50);
    chk_drained("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
